gcd_stein_core: RTL and testbench

//  Binary (Stein) GCD engine downstream of the SPI register bridge. Consumes the bridge's

---
 rtl/gcd_pkg.sv | 24 ++
 rtl/gcd_stein_core_if.sv | 41 ++++
 rtl/gcd_stein_step.sv | 45 ++++
 rtl/gcd_stein_core.sv | 129 ++++++++++++
 tb/tb_gcd_stein_core.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/gcd_pkg.sv
// Shared GCD definitions used by the core, the SPI bridge and the bench.
// Optional build macro honoured by the core: GCD_ITER_COUNT_EN.
package gcd_pkg;

  localparam int GCD_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_REDUCE,
    S_DONE
  } gcd_state_e;

  // Width of the shift accumulator k for a given operand width.
  function automatic int gcd_k_width(input int data_width);
    return $clog2(data_width + 1);
  endfunction

  // Width of the REDUCE-cycle counter for a given operand width.
  function automatic int gcd_iter_width(input int data_width);
    return $clog2(2 * data_width + 2);
  endfunction

endpackage

// File: rtl/gcd_stein_core_if.sv
// Bridge-to-core bundle: free-running operands in, result/status out.
// iter_count_o exists only when GCD_ITER_COUNT_EN is defined.
interface gcd_stein_core_if
  import gcd_pkg::*;
#(
  parameter int DATA_WIDTH = GCD_DATA_WIDTH
);

  // No handshake: the operands are level registers with no strobe, so the core
  // samples them every cycle and treats any difference from its launch copy as a request.
  logic [DATA_WIDTH-1:0] operand_a_i;
  logic [DATA_WIDTH-1:0] operand_b_i;
  logic [DATA_WIDTH-1:0] gcd_o;
  logic                  busy_o;
  logic                  done_o;
  gcd_state_e            state_o;
`ifdef GCD_ITER_COUNT_EN
  logic [gcd_iter_width(DATA_WIDTH)-1:0] iter_count_o;

  modport master (
    output operand_a_i, operand_b_i,
    input  gcd_o, busy_o, done_o, state_o, iter_count_o
  );

  modport slave (
    input  operand_a_i, operand_b_i,
    output gcd_o, busy_o, done_o, state_o, iter_count_o
  );
`else
  modport master (
    output operand_a_i, operand_b_i,
    input  gcd_o, busy_o, done_o, state_o
  );

  modport slave (
    input  operand_a_i, operand_b_i,
    output gcd_o, busy_o, done_o, state_o
  );
`endif

endinterface

// File: rtl/gcd_stein_step.sv
// One combinational Stein reduction step: next a/b/k, terminate flag and
// the shifted-back result that applies when terminating.
module gcd_stein_step #(
  parameter int DATA_WIDTH = 8,
  parameter int K_WIDTH    = 4
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [K_WIDTH-1:0]    k,
  output logic [DATA_WIDTH-1:0] a_nxt,
  output logic [DATA_WIDTH-1:0] b_nxt,
  output logic [K_WIDTH-1:0]    k_nxt,
  output logic                  term,
  output logic [DATA_WIDTH-1:0] result
);

  always_comb begin
    a_nxt  = a;
    b_nxt  = b;
    k_nxt  = k;
    term   = 1'b0;
    result = '0;
    if (a == '0) begin
      term   = 1'b1;
      result = b << k;
    end else if (b == '0) begin
      term   = 1'b1;
      result = a << k;
    end else if (!a[0] && !b[0]) begin
      a_nxt = a >> 1;
      b_nxt = b >> 1;
      k_nxt = k + K_WIDTH'(1);
    end else if (!a[0]) begin
      a_nxt = a >> 1;
    end else if (!b[0]) begin
      b_nxt = b >> 1;
    end else if (a >= b) begin
      // Both odd: the difference is even, so halve it in the same step.
      a_nxt = (a - b) >> 1;
    end else begin
      b_nxt = (b - a) >> 1;
    end
  end

endmodule

// File: rtl/gcd_stein_core.sv
// Sequential binary GCD engine fed by the bridge's free-running operand registers.
// Define GCD_ITER_COUNT_EN to add the iter_count_o debug readback.
module gcd_stein_core
  import gcd_pkg::*;
#(
  parameter int DATA_WIDTH = GCD_DATA_WIDTH
) (
  input  logic              clk_i,
  input  logic              nreset_i,
  gcd_stein_core_if.slave   bus
);

  localparam int K_WIDTH = gcd_k_width(DATA_WIDTH);

  gcd_state_e            state_q;
  logic [DATA_WIDTH-1:0] a_q, b_q;
  logic [DATA_WIDTH-1:0] la_q, lb_q;
  logic [K_WIDTH-1:0]    k_q;
  logic [DATA_WIDTH-1:0] gcd_q;
  logic                  busy_q;
  logic                  done_q;

  logic [DATA_WIDTH-1:0] a_nxt, b_nxt, step_result;
  logic [K_WIDTH-1:0]    k_nxt;
  logic                  step_term;
  logic                  chg;

  // Launch copies start at 0, so operands of 0/0 out of reset do not launch.
  assign chg = (bus.operand_a_i != la_q) | (bus.operand_b_i != lb_q);

  gcd_stein_step #(
    .DATA_WIDTH (DATA_WIDTH),
    .K_WIDTH    (K_WIDTH)
  ) u_step (
    .a      (a_q),
    .b      (b_q),
    .k      (k_q),
    .a_nxt  (a_nxt),
    .b_nxt  (b_nxt),
    .k_nxt  (k_nxt),
    .term   (step_term),
    .result (step_result)
  );

`ifdef GCD_ITER_COUNT_EN
  localparam int I_WIDTH = gcd_iter_width(DATA_WIDTH);
  logic [I_WIDTH-1:0] iter_q;
  logic [I_WIDTH-1:0] iter_count_q;
  assign bus.iter_count_o = iter_count_q;
`endif

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      la_q    <= '0;
      lb_q    <= '0;
      k_q     <= '0;
      gcd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef GCD_ITER_COUNT_EN
      iter_q       <= '0;
      iter_count_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (chg) begin
            state_q <= S_LOAD;
            busy_q  <= 1'b1;
          end
        end
        S_LOAD: begin
          a_q     <= bus.operand_a_i;
          b_q     <= bus.operand_b_i;
          la_q    <= bus.operand_a_i;
          lb_q    <= bus.operand_b_i;
          k_q     <= '0;
          state_q <= S_REDUCE;
`ifdef GCD_ITER_COUNT_EN
          iter_q  <= '0;
`endif
        end
        S_REDUCE: begin
          // A new operand pair abandons the run without touching gcd_o.
          if (chg) begin
            state_q <= S_LOAD;
          end else if (step_term) begin
            gcd_q   <= step_result;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
`ifdef GCD_ITER_COUNT_EN
            iter_count_q <= iter_q + I_WIDTH'(1);
`endif
          end else begin
            a_q <= a_nxt;
            b_q <= b_nxt;
            k_q <= k_nxt;
`ifdef GCD_ITER_COUNT_EN
            iter_q <= iter_q + I_WIDTH'(1);
`endif
          end
        end
        S_DONE: begin
          if (chg) begin
            state_q <= S_LOAD;
            busy_q  <= 1'b1;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gcd_o   = gcd_q;
  assign bus.busy_o  = busy_q;
  assign bus.done_o  = done_q;
  assign bus.state_o = state_q;

endmodule

// File: tb/tb_gcd_stein_core.sv
// Self-checking bench for gcd_stein_core against a Euclid reference model.
// Also checks iter_count_o when built with GCD_ITER_COUNT_EN.
module tb_gcd_stein_core;
  import gcd_pkg::*;

  localparam int W      = GCD_DATA_WIDTH;
  localparam int BUDGET = 24;
  localparam int MAXLAT = 2 * W + 3;

  logic clk;
  logic nreset;
  int   n_tests;
  int   n_fail;

  gcd_stein_core_if #(.DATA_WIDTH(W)) bus ();

  gcd_stein_core #(.DATA_WIDTH(W)) dut (
    .clk_i    (clk),
    .nreset_i (nreset),
    .bus      (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    int x, y, t;
    x = int'(a);
    y = int'(b);
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return W'(x);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_ops(input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk);
    #1;
    bus.operand_a_i = a;
    bus.operand_b_i = b;
  endtask

  // Observes BUDGET cycles after an operand change; cycle i is sampled on the
  // negedge following the i-th rising edge after the change.
  task automatic run_window(input logic [W-1:0] watch, input bit watch_en,
                            output int first_done, output int pulses,
                            output bit busy1, output bit watch_hit);
    first_done = -1;
    pulses     = 0;
    busy1      = 1'b0;
    watch_hit  = 1'b0;
    for (int i = 1; i <= BUDGET; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 1) busy1 = (bus.busy_o === 1'b1);
      if (bus.done_o === 1'b1) begin
        pulses++;
        if (first_done < 0) first_done = i;
      end
      if (watch_en && bus.gcd_o === watch) watch_hit = 1'b1;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bit busy_seen, done_seen;
    nreset = 1'b0;
    bus.operand_a_i = '0;
    bus.operand_b_i = '0;
    repeat (3) @(posedge clk);
    #2;
    n_tests++;
    if (bus.gcd_o !== '0 || bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.state_o !== S_IDLE) begin
      n_fail++;
      $display("FAIL reset_values: gcd=%0d busy=%b done=%b state=%0d, required 0/0/0/IDLE",
               bus.gcd_o, bus.busy_o, bus.done_o, bus.state_o);
    end
    nreset = 1'b1;
    busy_seen = 1'b0;
    done_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.busy_o !== 1'b0) busy_seen = 1'b1;
      if (bus.done_o !== 1'b0) done_seen = 1'b1;
    end
    n_tests++;
    if (busy_seen || done_seen || bus.gcd_o !== '0) begin
      n_fail++;
      $display("FAIL zero_idle: busy_seen=%b done_seen=%b gcd=%0d, required 0/0/0",
               busy_seen, done_seen, bus.gcd_o);
    end
`ifdef GCD_ITER_COUNT_EN
    n_tests++;
    if (bus.iter_count_o !== '0) begin
      n_fail++;
      $display("FAIL iter_reset: iter_count=%0d, required 0", bus.iter_count_o);
    end
`endif
  endtask

  task automatic test_basic();
    int fd, pulses;
    bit b1, hit;
    set_ops(8'd48, 8'd18);
    run_window('0, 1'b0, fd, pulses, b1, hit);
    n_tests++;
    if (!b1) begin
      n_fail++;
      $display("FAIL basic_busy: busy at cycle 1 = 0, required 1");
    end
    n_tests++;
    if (pulses != 1 || fd < 1 || fd > MAXLAT) begin
      n_fail++;
      $display("FAIL basic_done: pulses=%0d first=%0d, required 1 pulse within %0d", pulses, fd, MAXLAT);
    end
    n_tests++;
    if (bus.gcd_o !== ref_gcd(8'd48, 8'd18)) begin
      n_fail++;
      $display("FAIL basic_gcd: got %0d, required %0d", bus.gcd_o, ref_gcd(8'd48, 8'd18));
    end
  endtask

  task automatic test_zero();
    int fd, pulses;
    bit b1, hit;
    set_ops(8'd0, 8'd25);
    run_window('0, 1'b0, fd, pulses, b1, hit);
    n_tests++;
    if (fd != 3 || pulses != 1) begin
      n_fail++;
      $display("FAIL zero_latency: done first at cycle %0d (%0d pulses), required cycle 3 (1 pulse)", fd, pulses);
    end
    n_tests++;
    if (bus.gcd_o !== 8'd25) begin
      n_fail++;
      $display("FAIL zero_a: got %0d, required 25", bus.gcd_o);
    end
    set_ops(8'd0, 8'd0);
    run_window('0, 1'b0, fd, pulses, b1, hit);
    n_tests++;
    if (bus.gcd_o !== 8'd0 || pulses != 1 || fd != 3) begin
      n_fail++;
      $display("FAIL zero_both: gcd=%0d pulses=%0d first=%0d, required 0/1/3", bus.gcd_o, pulses, fd);
    end
  endtask

  task automatic test_kpath();
    int fd, pulses;
    bit b1, hit;
    set_ops(8'd255, 8'd254);
    run_window('0, 1'b0, fd, pulses, b1, hit);
    n_tests++;
    if (bus.gcd_o !== 8'd1 || pulses != 1 || fd > MAXLAT) begin
      n_fail++;
      $display("FAIL coprime: gcd=%0d pulses=%0d first=%0d, required 1/1/<=%0d", bus.gcd_o, pulses, fd, MAXLAT);
    end
`ifdef GCD_ITER_COUNT_EN
    n_tests++;
    if (bus.iter_count_o == '0 || bus.iter_count_o > 17) begin
      n_fail++;
      $display("FAIL iter_range: iter_count=%0d, required 1..17", bus.iter_count_o);
    end
`endif
    set_ops(8'd128, 8'd64);
    run_window('0, 1'b0, fd, pulses, b1, hit);
    n_tests++;
    if (bus.gcd_o !== 8'd64 || pulses != 1) begin
      n_fail++;
      $display("FAIL kpath: gcd=%0d pulses=%0d, required 64/1", bus.gcd_o, pulses);
    end
  endtask

  task automatic test_abort();
    int  pulses, first;
    bit  hit50;
    set_ops(8'd200, 8'd150);
    pulses = 0;
    first  = -1;
    hit50  = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      #1;
      if (i == 2) bus.operand_b_i = 8'd35;
      @(negedge clk);
      if (bus.done_o === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
      end
      if (bus.gcd_o === 8'd50) hit50 = 1'b1;
    end
    n_tests++;
    if (pulses != 1 || hit50) begin
      n_fail++;
      $display("FAIL abort_done: pulses=%0d saw50=%b, required 1/0", pulses, hit50);
    end
    n_tests++;
    if (bus.gcd_o !== ref_gcd(8'd200, 8'd35)) begin
      n_fail++;
      $display("FAIL abort_gcd: got %0d, required %0d", bus.gcd_o, ref_gcd(8'd200, 8'd35));
    end
  endtask

  task automatic test_reset_mid();
    int fd, pulses;
    bit b1, hit;
    set_ops(8'd180, 8'd120);
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (bus.busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL midrun_busy: busy=%b before reset, required 1", bus.busy_o);
    end
    #2;
    nreset = 1'b0;
    #1;
    n_tests++;
    if (bus.gcd_o !== '0 || bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: gcd=%0d busy=%b done=%b, required 0/0/0", bus.gcd_o, bus.busy_o, bus.done_o);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    nreset = 1'b1;
    run_window('0, 1'b0, fd, pulses, b1, hit);
    n_tests++;
    if (bus.gcd_o !== ref_gcd(8'd180, 8'd120) || pulses != 1) begin
      n_fail++;
      $display("FAIL relaunch: gcd=%0d pulses=%0d, required %0d/1", bus.gcd_o, pulses, ref_gcd(8'd180, 8'd120));
    end
  endtask

  task automatic test_random();
    int fd, pulses;
    bit b1, hit;
    logic [W-1:0] a, b, exp;
    logic [W-1:0] exp_q[$];
    for (int n = 0; n < 30; n++) begin
      a = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(0, 255));
      b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(0, 255));
      if (a == bus.operand_a_i && b == bus.operand_b_i) b = b ^ W'(1);
      exp_q.push_back(ref_gcd(a, b));
      set_ops(a, b);
      run_window('0, 1'b0, fd, pulses, b1, hit);
      exp = exp_q.pop_front();
      n_tests++;
      if (bus.gcd_o !== exp || pulses != 1 || fd > MAXLAT) begin
        n_fail++;
        $display("FAIL random_gcd: a=%0d b=%0d got %0d pulses=%0d first=%0d, required %0d/1/<=%0d",
                 a, b, bus.gcd_o, pulses, fd, exp, MAXLAT);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_basic();
    test_zero();
    test_kpath();
    test_abort();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
